// File: rtl/spi_btn_master_if.sv
// Handshake and serial-bus signals of the button-driven SPI master.
interface spi_btn_master_if #(
  parameter int DATA_W = 8
) ();
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              miso;
  logic              sclk;
  logic              mosi;
  logic              cs_n;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;

  modport master (
    input  start, tx_data, miso,
    output sclk, mosi, cs_n, busy, done, rx_data
  );

  modport slave (
    output start, tx_data, miso,
    input  sclk, mosi, cs_n, busy, done, rx_data
  );
endinterface

// File: rtl/spi_btn_master.sv
// SPI mode-0 master, one full-duplex MSB-first word per start pulse.
// Define SPI_START_QUEUE_EN to add a one-entry pending-start slot.
module spi_btn_master #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 50
) (
  input  logic              clock,
  input  logic              n_reset,
  spi_btn_master_if.master  bus
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div, div_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] tx_sh, tx_nxt, rx_sh, rx_nxt, rxd_q, rxd_nxt;
  logic              sclk_q, sclk_nxt, mosi_q, mosi_nxt, cs_q, cs_nxt;
  logic              busy_q, busy_nxt, done_q, done_nxt;
  logic              tick, load;
  logic [DATA_W-1:0] load_word;
`ifdef SPI_START_QUEUE_EN
  logic              pend_vld, pend_vld_nxt;
  logic [DATA_W-1:0] pend_data, pend_data_nxt;
`endif

  assign tick = (div == DIV_LAST);

  always_comb begin
    state_nxt = state;
    div_nxt   = div;
    cnt_nxt   = cnt;
    tx_nxt    = tx_sh;
    rx_nxt    = rx_sh;
    rxd_nxt   = rxd_q;
    sclk_nxt  = sclk_q;
    mosi_nxt  = mosi_q;
    cs_nxt    = cs_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    load      = 1'b0;
    load_word = bus.tx_data;
`ifdef SPI_START_QUEUE_EN
    pend_vld_nxt  = pend_vld;
    pend_data_nxt = pend_data;
    if (busy_q && bus.start && !pend_vld) begin
      pend_vld_nxt  = 1'b1;
      pend_data_nxt = bus.tx_data;
    end
`endif
    if (state != IDLE) div_nxt = tick ? '0 : div + 1'b1;

    unique case (state)
      IDLE: if (bus.start) load = 1'b1;
      SETUP: if (tick) begin
        sclk_nxt  = 1'b1;
        rx_nxt    = {rx_sh[DATA_W-2:0], bus.miso};
        cnt_nxt   = '0;
        state_nxt = SHIFT;
      end
      SHIFT: if (tick) begin
        if (sclk_q) begin
          sclk_nxt = 1'b0;
          if (cnt == BIT_LAST) state_nxt = HOLD;
          else begin
            tx_nxt   = tx_sh << 1;
            mosi_nxt = tx_sh[DATA_W-2];
            cnt_nxt  = cnt + 1'b1;
          end
        end else begin
          sclk_nxt = 1'b1;
          rx_nxt   = {rx_sh[DATA_W-2:0], bus.miso};
        end
      end
      HOLD: if (tick) begin
        cs_nxt    = 1'b1;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        rxd_nxt   = rx_sh;
        mosi_nxt  = 1'b0;
        state_nxt = IDLE;
`ifdef SPI_START_QUEUE_EN
        if (pend_vld) state_nxt = GAP;
`endif
      end
`ifdef SPI_START_QUEUE_EN
      // cs_n stays high for one divider period before the queued frame
      GAP: if (tick) begin
        load         = 1'b1;
        load_word    = pend_data;
        pend_vld_nxt = 1'b0;
      end
`endif
      default: state_nxt = IDLE;
    endcase

    if (load) begin
      div_nxt   = '0;
      tx_nxt    = load_word;
      rx_nxt    = '0;
      mosi_nxt  = load_word[DATA_W-1];
      cs_nxt    = 1'b0;
      busy_nxt  = 1'b1;
      state_nxt = SETUP;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state  <= IDLE;
      div    <= '0;
      cnt    <= '0;
      tx_sh  <= '0;
      rx_sh  <= '0;
      rxd_q  <= '0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      cs_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      div    <= div_nxt;
      cnt    <= cnt_nxt;
      tx_sh  <= tx_nxt;
      rx_sh  <= rx_nxt;
      rxd_q  <= rxd_nxt;
      sclk_q <= sclk_nxt;
      mosi_q <= mosi_nxt;
      cs_q   <= cs_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

`ifdef SPI_START_QUEUE_EN
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      pend_vld  <= 1'b0;
      pend_data <= '0;
    end else begin
      pend_vld  <= pend_vld_nxt;
      pend_data <= pend_data_nxt;
    end
  end
`endif

  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.cs_n    = cs_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rxd_q;
endmodule

// File: tb/tb_spi_btn_master.sv
// Randomized bench for spi_btn_master (DATA_W=8, CLK_DIV=4) against a frame-level model.
module tb_spi_btn_master;
  localparam int DW = 8;
  localparam int H  = 4;
  localparam int LAT = (2*DW + 1) * H;
`ifdef SPI_START_QUEUE_EN
  localparam int EXP_GAP = H;
`else
  localparam int EXP_GAP = -1;
`endif

  logic clock = 1'b0;
  logic n_reset = 1'b0;
  int   miso_mode = 0;
  int   n_cmp = 0, n_bad = 0;
  int   viol_cs = 0, viol_mo = 0;

  spi_btn_master_if #(.DATA_W(DW)) bus ();
  spi_btn_master #(.DATA_W(DW), .CLK_DIV(H)) dut (.clock(clock), .n_reset(n_reset), .bus(bus));

  always #5 clock = ~clock;

  // 0: loopback, 1: tied high, 2: tied low
  assign bus.miso = (miso_mode == 0) ? bus.mosi : (miso_mode == 1);

  function automatic logic [DW-1:0] model_rx(input logic [DW-1:0] tx, input int mm);
    return (mm == 0) ? tx : (mm == 1) ? '1 : '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // bus invariants: no sclk outside a frame, mosi quiet around rising sclk
  logic ps = 0, pm = 0, prise = 0, pchg = 0;
  always @(negedge clock) begin
    logic rise, chg;
    rise = bus.sclk && !ps;
    chg  = (bus.mosi !== pm);
    if (bus.cs_n && bus.sclk) viol_cs++;
    if ((rise && (chg || pchg)) || (prise && chg)) viol_mo++;
    ps = bus.sclk; pm = bus.mosi; prise = rise; pchg = chg;
  end

  // Call at a negedge; returns at the negedge where done is seen.
  task automatic run_frame(input logic [DW-1:0] tx, input int mm, input int late_k,
                           input logic [DW-1:0] late_tx, input int rst_k);
    logic [DW-1:0] seen = '0;
    int rises = 0, falls = 0, busy_n = 0, done_k = -1, bad_edge = 0, cs_done = 0;
    logic psclk = 1'b0;
    miso_mode = mm;
    bus.tx_data = tx;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.tx_data = DW'($urandom);
    for (int k = 0; k < 200 && done_k < 0; k++) begin
      @(negedge clock);
      if (bus.start) bus.start = 1'b0;
      if (k == 0) begin
        chk("cs_fall", bus.cs_n, 0);
        chk("mosi_msb", bus.mosi, tx[DW-1]);
      end
      if (k == rst_k) begin
        n_reset = 1'b0;
        #1;
        chk("rst_cs", bus.cs_n, 1);
        chk("rst_sclk", bus.sclk, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mosi", bus.mosi, 0);
        chk("rst_rx", bus.rx_data, 0);
        @(negedge clock);
        n_reset = 1'b1;
        return;
      end
      if (bus.busy) busy_n++;
      if (bus.sclk && !psclk) begin
        if (k != H*(2*rises + 1)) bad_edge++;
        seen = {seen[DW-2:0], bus.mosi};
        rises++;
      end
      if (!bus.sclk && psclk) begin
        if (k != H*2*(falls + 1)) bad_edge++;
        falls++;
      end
      psclk = bus.sclk;
      if (bus.done) begin
        done_k = k;
        cs_done = bus.cs_n;
      end
      if (k == late_k) begin
        bus.start = 1'b1;
        bus.tx_data = late_tx;
      end
    end
    chk("done_lat", done_k, LAT);
    chk("busy_len", busy_n, LAT);
    chk("rises", rises, DW);
    chk("edge_time", bad_edge, 0);
    chk("mosi_bits", seen, tx);
    chk("cs_at_done", cs_done, 1);
    chk("rx_data", bus.rx_data, model_rx(tx, mm));
  endtask

  initial begin
    int gap;
    bit got;
    logic [DW-1:0] a, b;
    bus.start = 1'b0;
    bus.tx_data = '0;
    repeat (3) @(negedge clock);
    chk("r_cs", bus.cs_n, 1);
    chk("r_sclk", bus.sclk, 0);
    chk("r_mosi", bus.mosi, 0);
    chk("r_busy", bus.busy, 0);
    chk("r_done", bus.done, 0);
    chk("r_rx", bus.rx_data, 0);
    n_reset = 1'b1;
    @(negedge clock);

    run_frame(8'hA5, 0, -1, 0, -1);
    @(negedge clock); run_frame(8'h00, 1, -1, 0, -1);
    @(negedge clock); run_frame(8'h00, 2, -1, 0, -1);

    // second start 20 clocks into a frame
    @(negedge clock); run_frame(8'h81, 0, 20, 8'h3C, -1);
    gap = -1;
    for (int j = 1; j <= 30 && gap < 0; j++) begin
      @(negedge clock);
      if (!bus.cs_n) gap = j;
    end
    chk("q_gap", gap, EXP_GAP);
    if (gap > 0) begin
      got = 0;
      for (int j = 0; j < 100 && !got; j++) begin
        @(negedge clock);
        if (bus.done) got = 1;
      end
      chk("q_done", got, 1);
      chk("q_rx", bus.rx_data, 8'h3C);
    end

    // reset mid-frame, then a fresh frame
    repeat (5) @(negedge clock);
    run_frame(8'hC3, 0, -1, 0, 30);
    @(negedge clock); run_frame(8'h5A, 0, -1, 0, -1);

    // start in the done cycle: back-to-back frames
    a = DW'($urandom); b = DW'($urandom);
    @(negedge clock); run_frame(a, 0, -1, 0, -1);
    run_frame(b, 0, -1, 0, -1);

    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      run_frame(DW'($urandom), int'($urandom_range(0, 2)), -1, 0, -1);
    end
    repeat (5) @(negedge clock);
    chk("sclk_vs_cs", viol_cs, 0);
    chk("mosi_stable", viol_mo, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
